// File: rtl/ts_pkg.sv
// Shared constants and types for the 32-to-10 word unpacker.
package ts_pkg;

    localparam int unsigned SAMPLE_W    = 10;
    localparam int unsigned WORD_W      = 32;
    localparam int unsigned FILL_W      = 7;

    // Payload bits contributed by one memory word in each layout
    localparam int unsigned BPW_ALIGNED = 30;
    localparam int unsigned BPW_PACKED  = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } ts_state_e;

    function automatic int unsigned bits_per_word(input int unsigned layout);
        return (layout != 0) ? BPW_PACKED : BPW_ALIGNED;
    endfunction

endpackage

// File: rtl/ts_word_unpacker_if.sv
// Word-side and sample-side handshake bundle for ts_word_unpacker.
// With TS_UNPACK_STATS_EN defined the bundle also carries the statistics counters.
interface ts_word_unpacker_if;

    logic [31:0] WORD_IN;
    logic        WORD_VALID;
    logic        WORD_READY;
    logic        FLUSH;
    logic [9:0]  DATA_OUT;
    logic        DATA_VALID;
    logic        DATA_READY;
    logic [6:0]  FILL_LEVEL;
    logic [1:0]  STATE;
`ifdef TS_UNPACK_STATS_EN
    logic [31:0] WORDS_CONSUMED;
    logic [31:0] SAMPLES_EMITTED;
    logic [15:0] BITS_DROPPED;
`endif

`ifdef TS_UNPACK_STATS_EN
    modport master (
        output WORD_IN, WORD_VALID, FLUSH, DATA_READY,
        input  WORD_READY, DATA_OUT, DATA_VALID, FILL_LEVEL, STATE,
        input  WORDS_CONSUMED, SAMPLES_EMITTED, BITS_DROPPED
    );
    modport slave (
        input  WORD_IN, WORD_VALID, FLUSH, DATA_READY,
        output WORD_READY, DATA_OUT, DATA_VALID, FILL_LEVEL, STATE,
        output WORDS_CONSUMED, SAMPLES_EMITTED, BITS_DROPPED
    );
`else
    modport master (
        output WORD_IN, WORD_VALID, FLUSH, DATA_READY,
        input  WORD_READY, DATA_OUT, DATA_VALID, FILL_LEVEL, STATE
    );
    modport slave (
        input  WORD_IN, WORD_VALID, FLUSH, DATA_READY,
        output WORD_READY, DATA_OUT, DATA_VALID, FILL_LEVEL, STATE
    );
`endif

endinterface

// File: rtl/ts_bit_accumulator.sv
// MSB-aligned bit accumulator with fill counter.
// take10 removes the oldest 10 bits; append places BPW new bits directly
// below whatever remains after that removal; clear discards everything.
module ts_bit_accumulator
    import ts_pkg::*;
#(
    parameter int unsigned ACC_W = 64,
    parameter int unsigned BPW   = BPW_ALIGNED
) (
    input  logic                CLOCK,
    input  logic                RESET,
    input  logic                clear,
    input  logic                take10,
    input  logic                append,
    input  logic [WORD_W-1:0]   word,
    output logic [SAMPLE_W-1:0] top10,
    output logic [FILL_W-1:0]   fill
);

    logic [ACC_W-1:0]  acc_q;
    logic [ACC_W-1:0]  acc_shift;
    logic [ACC_W-1:0]  acc_d;
    logic [ACC_W-1:0]  word_ext;
    logic [FILL_W-1:0] fill_q;
    logic [FILL_W-1:0] fill_shift;
    logic [FILL_W-1:0] fill_d;

    // Unused top bits of the word in the aligned layout
    logic unused_word_bits;
    assign unused_word_bits = ^word;

    // Next accumulator: shift first, then append at the post-shift fill position
    always_comb begin
        acc_shift  = take10 ? (acc_q << SAMPLE_W) : acc_q;
        fill_shift = take10 ? (fill_q - FILL_W'(SAMPLE_W)) : fill_q;
        word_ext   = '0;
        word_ext[ACC_W-1 -: BPW] = word[BPW-1:0];
        acc_d      = acc_shift;
        fill_d     = fill_shift;
        if (append) begin
            acc_d  = acc_shift | (word_ext >> fill_shift);
            fill_d = fill_shift + FILL_W'(BPW);
        end
        if (clear) begin
            acc_d  = '0;
            fill_d = '0;
        end
    end

    // Accumulator and fill registers
    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            acc_q  <= '0;
            fill_q <= '0;
        end else begin
            acc_q  <= acc_d;
            fill_q <= fill_d;
        end
    end

    assign top10 = acc_q[ACC_W-1 -: SAMPLE_W];
    assign fill  = fill_q;

endmodule

// File: rtl/ts_word_unpacker.sv
// Read-side gearbox: 32-bit memory words in, 10-bit samples out.
// PACKED=0: three samples per word in [29:20],[19:10],[9:0].
// PACKED=1: contiguous MSB-first bitstream, samples may straddle words.
// ACC_W must be at least 42.
// Optional TS_UNPACK_STATS_EN adds WORDS_CONSUMED, SAMPLES_EMITTED, BITS_DROPPED.
module ts_word_unpacker
    import ts_pkg::*;
#(
    parameter int unsigned PACKED = 0,
    parameter int unsigned ACC_W  = 64
) (
    input  logic               CLOCK,
    input  logic               RESET,
    ts_word_unpacker_if.slave  bus
);

    localparam int unsigned       BPW         = bits_per_word(PACKED);
    localparam logic [FILL_W-1:0] READY_MAX   = FILL_W'(ACC_W - WORD_W);
    localparam logic [FILL_W-1:0] SAMPLE_FILL = FILL_W'(SAMPLE_W);

    ts_state_e           state_q;
    logic [SAMPLE_W-1:0] data_q;
    logic                valid_q;
    logic [SAMPLE_W-1:0] top10;
    logic [FILL_W-1:0]   fill;
    logic                advance;
    logic                take;
    logic                word_ready;
    logic                accept;
    logic                drain_low;

    ts_bit_accumulator #(
        .ACC_W (ACC_W),
        .BPW   (BPW)
    ) u_acc (
        .CLOCK  (CLOCK),
        .RESET  (RESET),
        .clear  (drain_low),
        .take10 (take),
        .append (accept),
        .word   (bus.WORD_IN),
        .top10  (top10),
        .fill   (fill)
    );

    // Handshake decode; WORD_READY depends on registers only
    always_comb begin
        advance    = !valid_q || bus.DATA_READY;
        take       = advance && (fill >= SAMPLE_FILL);
        word_ready = (state_q != ST_DRAIN) && (fill <= READY_MAX);
        accept     = bus.WORD_VALID && word_ready;
        drain_low  = (state_q == ST_DRAIN) && (fill < SAMPLE_FILL);
    end

    // Output register and record state machine
    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            state_q <= ST_IDLE;
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            if (advance) begin
                if (take) begin
                    data_q  <= top10;
                    valid_q <= 1'b1;
                end else begin
                    valid_q <= 1'b0;
                end
            end
            case (state_q)
                ST_IDLE: begin
                    // A flush arriving with the first word still closes the record
                    if (accept) begin
                        state_q <= bus.FLUSH ? ST_DRAIN : ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (bus.FLUSH) begin
                        state_q <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    // Residue is cleared while fill < 10; leave once the output slot frees
                    if (drain_low && advance) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.WORD_READY = word_ready;
    assign bus.DATA_OUT   = data_q;
    assign bus.DATA_VALID = valid_q;
    assign bus.FILL_LEVEL = fill;
    assign bus.STATE      = state_q;

`ifdef TS_UNPACK_STATS_EN
    logic [31:0] words_q;
    logic [31:0] samples_q;
    logic [15:0] dropped_q;

    // Free-running statistics, wrapping at their width
    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            words_q   <= '0;
            samples_q <= '0;
            dropped_q <= '0;
        end else begin
            if (accept) begin
                words_q <= words_q + 32'd1;
            end
            if (valid_q && bus.DATA_READY) begin
                samples_q <= samples_q + 32'd1;
            end
            if (drain_low) begin
                dropped_q <= dropped_q + 16'(fill);
            end
        end
    end

    assign bus.WORDS_CONSUMED  = words_q;
    assign bus.SAMPLES_EMITTED = samples_q;
    assign bus.BITS_DROPPED    = dropped_q;
`endif

endmodule

// File: tb/tb_ts_word_unpacker.sv
// Scoreboard bench for ts_word_unpacker: one PACKED=0 and one PACKED=1 instance.
module tb_ts_word_unpacker;

    logic CLOCK = 1'b0;
    logic RESET = 1'b1;
    always #5 CLOCK = ~CLOCK;

    ts_word_unpacker_if if0();
    ts_word_unpacker_if if1();

    ts_word_unpacker #(.PACKED(0), .ACC_W(64)) u0 (.CLOCK(CLOCK), .RESET(RESET), .bus(if0));
    ts_word_unpacker #(.PACKED(1), .ACC_W(64)) u1 (.CLOCK(CLOCK), .RESET(RESET), .bus(if1));

    int checks = 0;
    int errors = 0;

    logic [9:0] exp0[$];
    logic [9:0] exp1[$];
    bit         bits1[$];
    int         dropped1 = 0;
    int         pops1 = 0;
    bit         stall1 = 0;
    logic [9:0] held1 = '0;
    bit         sust1 = 0;
    int         rdy_lo = 0;
    int         rdy_hi = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Reference models: aligned slices, and a plain MSB-first bit queue
    task automatic model0_word(input logic [31:0] w);
        exp0.push_back(w[29:20]);
        exp0.push_back(w[19:10]);
        exp0.push_back(w[9:0]);
    endtask

    task automatic model1_word(input logic [31:0] w);
        for (int i = 31; i >= 0; i--) bits1.push_back(w[i]);
        while (bits1.size() >= 10) begin
            logic [9:0] s;
            for (int j = 9; j >= 0; j--) s[j] = bits1.pop_front();
            exp1.push_back(s);
        end
    endtask

    task automatic send0(input logic [31:0] w);
        int n;
        bit done;
        n = 0;
        done = 0;
        if0.WORD_IN = w;
        if0.WORD_VALID = 1'b1;
        while (!done) begin
            @(negedge CLOCK);
            if (if0.WORD_READY) done = 1;
            else begin
                n++;
                if (n > 200) begin
                    chk("send0_timeout", if0.WORD_READY, 1);
                    done = 1;
                end
            end
        end
        @(posedge CLOCK);
        #1;
        if0.WORD_VALID = 1'b0;
        model0_word(w);
    endtask

    task automatic send1(input logic [31:0] w);
        int n;
        bit done;
        n = 0;
        done = 0;
        if1.WORD_IN = w;
        if1.WORD_VALID = 1'b1;
        while (!done) begin
            @(negedge CLOCK);
            if (if1.WORD_READY) done = 1;
            else begin
                n++;
                if (n > 200) begin
                    chk("send1_timeout", if1.WORD_READY, 1);
                    done = 1;
                end
            end
        end
        @(posedge CLOCK);
        #1;
        if1.WORD_VALID = 1'b0;
        model1_word(w);
    endtask

    task automatic flush0();
        if0.FLUSH = 1'b1;
        @(posedge CLOCK);
        #1;
        if0.FLUSH = 1'b0;
    endtask

    task automatic flush1();
        if1.FLUSH = 1'b1;
        @(posedge CLOCK);
        #1;
        if1.FLUSH = 1'b0;
        dropped1 += bits1.size();
        bits1.delete();
    endtask

    task automatic wait_idle0();
        int n;
        n = 0;
        while (if0.STATE != 2'd0 && n < 100) begin
            @(posedge CLOCK);
            #1;
            n++;
        end
        chk("idle0", if0.STATE, 0);
    endtask

    task automatic wait_idle1();
        int n;
        n = 0;
        while (if1.STATE != 2'd0 && n < 100) begin
            @(posedge CLOCK);
            #1;
            n++;
        end
        chk("idle1", if1.STATE, 0);
    endtask

    // Monitor for the aligned instance
    always @(negedge CLOCK) begin
        if (if0.DATA_VALID && if0.DATA_READY) begin
            if (exp0.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sample0: actual=%0h required=none", if0.DATA_OUT);
            end else begin
                chk("sample0", if0.DATA_OUT, exp0.pop_front());
            end
        end
    end

    // Monitor for the contiguous instance: order, hold under stall, fill bound, throughput
    always @(negedge CLOCK) begin
        if (stall1) chk("hold1", if1.DATA_OUT, held1);
        if (if1.DATA_VALID && if1.DATA_READY) begin
            pops1++;
            if (exp1.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sample1: actual=%0h required=none", if1.DATA_OUT);
            end else begin
                chk("sample1", if1.DATA_OUT, exp1.pop_front());
            end
        end
        stall1 = if1.DATA_VALID && !if1.DATA_READY;
        held1  = if1.DATA_OUT;
        chk("fill_max1", (if1.FILL_LEVEL <= 7'd64), 1);
        if (sust1) begin
            chk("sustain1", if1.DATA_VALID, 1);
            if (if1.WORD_READY) rdy_hi++;
            else rdy_lo++;
        end
    end

    logic [31:0] bp_words[6] = '{32'h01234567, 32'h89ABCDEF, 32'hFEDCBA98,
                                 32'h76543210, 32'h0F1E2D3C, 32'h4B5A6978};
    logic [31:0] alt_words[5] = '{32'hFFC00FFC, 32'h00FFC00F, 32'hFC00FFC0,
                                  32'h0FFC00FF, 32'hC00FFC00};

    initial begin
        if0.WORD_IN = '0; if0.WORD_VALID = 0; if0.FLUSH = 0; if0.DATA_READY = 1;
        if1.WORD_IN = '0; if1.WORD_VALID = 0; if1.FLUSH = 0; if1.DATA_READY = 1;

        // Reset values
        #12;
        chk("rst_valid0", if0.DATA_VALID, 0);
        chk("rst_fill0",  if0.FILL_LEVEL, 0);
        chk("rst_state0", if0.STATE, 0);
        chk("rst_out0",   if0.DATA_OUT, 0);
        chk("rst_ready0", if0.WORD_READY, 1);
        chk("rst_valid1", if1.DATA_VALID, 0);
        chk("rst_fill1",  if1.FILL_LEVEL, 0);
        chk("rst_state1", if1.STATE, 0);
        chk("rst_ready1", if1.WORD_READY, 1);
        RESET = 1'b0;
        @(posedge CLOCK);
        #1;

        // Aligned single word: 0x123, 0x115, 0x278 with fill 30/20/10/0
        send0(32'h12345678);
        chk("t1_fill30",  if0.FILL_LEVEL, 30);
        chk("t1_lat",     if0.DATA_VALID, 0);
        chk("t1_state",   if0.STATE, 1);
        @(posedge CLOCK); #1;
        chk("t1_out0",    if0.DATA_OUT, 10'h123);
        chk("t1_fill20",  if0.FILL_LEVEL, 20);
        @(posedge CLOCK); #1;
        chk("t1_out1",    if0.DATA_OUT, 10'h115);
        chk("t1_fill10",  if0.FILL_LEVEL, 10);
        @(posedge CLOCK); #1;
        chk("t1_out2",    if0.DATA_OUT, 10'h278);
        chk("t1_fill0",   if0.FILL_LEVEL, 0);
        flush0();
        wait_idle0();

        // Contiguous alternating stream, exact multiple of 10 bits
        for (int k = 0; k < 5; k++) send1(alt_words[k]);
        flush1();
        wait_idle1();
        chk("t2_fill", if1.FILL_LEVEL, 0);
`ifdef TS_UNPACK_STATS_EN
        chk("t2_dropped", if1.BITS_DROPPED, 0);
`endif

        // One all-ones word then flush: three 0x3FF, two bits dropped
        send1(32'hFFFFFFFF);
        flush1();
        wait_idle1();
        chk("t3_fill", if1.FILL_LEVEL, 0);
        chk("t3_model_drop", dropped1, 2);
`ifdef TS_UNPACK_STATS_EN
        chk("t3_dropped", if1.BITS_DROPPED, 2);
`endif

        // Backpressure: fill parks at 54 with WORD_READY low
        if1.DATA_READY = 1'b0;
        fork
            begin
                for (int k = 0; k < 6; k++) send1(bp_words[k]);
            end
            begin
                repeat (20) @(negedge CLOCK);
                chk("t4_ready_low", if1.WORD_READY, 0);
                chk("t4_fill54",    if1.FILL_LEVEL, 54);
                chk("t4_valid",     if1.DATA_VALID, 1);
                @(posedge CLOCK); #1;
                if1.DATA_READY = 1'b1;
            end
        join
        flush1();
        wait_idle1();

        // Sustained accept and emit
        send1(32'h13579BDF);
        @(posedge CLOCK); #1;
        sust1 = 1;
        for (int k = 1; k < 12; k++) send1(32'h13579BDF ^ (32'h11111111 * k));
        sust1 = 0;
        chk("t5_ready_toggles", (rdy_lo > 0) && (rdy_hi > 0), 1);
        flush1();
        wait_idle1();

        // Reset in the middle of a drain
        if1.DATA_READY = 1'b0;
        send1(32'hDEADBEEF);
        send1(32'hCAFEF00D);
        flush1();
        chk("t6_drain", if1.STATE, 2);
        #2;
        RESET = 1'b1;
        #1;
        chk("t6_valid", if1.DATA_VALID, 0);
        chk("t6_fill",  if1.FILL_LEVEL, 0);
        chk("t6_state", if1.STATE, 0);
`ifdef TS_UNPACK_STATS_EN
        chk("t6_words_rst", if1.WORDS_CONSUMED, 0);
`endif
        exp0.delete();
        exp1.delete();
        bits1.delete();
        stall1 = 0;
        dropped1 = 0;
        pops1 = 0;
        #4;
        RESET = 1'b0;
        @(posedge CLOCK); #1;
        if1.DATA_READY = 1'b1;
        send1(32'hA5A55A5A);
        chk("t6_lat0", if1.DATA_VALID, 0);
        chk("t6_fill32", if1.FILL_LEVEL, 32);
        @(posedge CLOCK); #1;
        chk("t6_lat1", if1.DATA_VALID, 1);
        chk("t6_first", if1.DATA_OUT, 10'h296);
        flush1();
        wait_idle1();

        // Everything expected has been seen
        repeat (5) @(posedge CLOCK);
        #1;
        chk("left0", exp0.size(), 0);
        chk("left1", exp1.size(), 0);
`ifdef TS_UNPACK_STATS_EN
        chk("words1",   if1.WORDS_CONSUMED, 1);
        chk("samples1", if1.SAMPLES_EMITTED, pops1);
        chk("drop1",    if1.BITS_DROPPED, dropped1);
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
